alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Operand-fetch stage sitting directly upstream of the ALU. Holds the
//  register file, reads two sources, selects an optional immediate for
//  operand 1, and detects read-after-write hazards against the ALU
//  in flight (stalling when needed).
//  Presents registered reg0/reg1/alu_op to the ALU. The writeback bus
//  derived from the ALU result returns through the wb_* ports.
// PARAMETERS
//  DATA_W   16  operand/register width
//  REG_CNT  16  number of registers; ADDR_W = $clog2(REG_CNT)
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst_n      in   1       synchronous, active-low reset
//  in_valid   in   1       decoded instruction present
//  in_ready   out  1       stage can accept (combinational, = ~hazard)
//  in_src0    in   ADDR_W  source register for reg0
//  in_src1    in   ADDR_W  source register for reg1
//  in_dst     in   ADDR_W  destination register
//  in_dst_we  in   1       instruction writes in_dst
//  in_use_imm in   1       reg1 takes in_imm instead of in_src1
//  in_imm     in   DATA_W  immediate operand
//  in_op      in   4       ALU opcode, passed through
//  flush      in   1       drop instruction in output register
//  wb_en      in   1       register write strobe
//  wb_addr    in   ADDR_W  write address
//  wb_data    in   DATA_W  write data
//  reg0       out  DATA_W  ALU operand 0 (registered)
//  reg1       out  DATA_W  ALU operand 1 (registered)
//  alu_op     out  4       ALU opcode (registered)
//  out_valid  out  1       reg0/reg1/alu_op hold a live instruction
//  out_dst    out  ADDR_W  destination of the live instruction
//  out_dst_we out  1       live instruction writes out_dst
// BEHAVIOUR
//  - Reset: all outputs 0, all registers 0; in_ready=1 after reset.
//  - Register 0 always reads 0. Writes to register 0 are ignored and never create a hazard.
//  - Register file write: at posedge when wb_en && wb_addr!=0.
//  - Accept: in_valid && in_ready at posedge.
//    - Latches reg0=R[src0], reg1 = in_use_imm ? in_imm : R[src1].
//    - Latches alu_op, out_dst, out_dst_we, and sets out_valid=1.
//  - No accept: out_valid<=0 and out_dst_we<=0 (bubble). reg0/reg1/alu_op hold their values.
//  - Latency: operands are visible one cycle after accept. The ALU result follows one cycle later.
//    Writeback is expected on wb_* in that same cycle (2 cycles after accept).
//  - Hazard: a source is "used" when it is nonzero. src1 counts only when !in_use_imm.
//    A hazard exists if any used source matches a pending destination:
//    - P1 = out_dst when out_valid && out_dst_we (result not yet computed).
//    - P2 = wb_addr when wb_en (only without the bypass, see CONFIGURATION).
//  - While a hazard exists: in_ready=0, the instruction is held upstream, and a bubble is issued.
//  - Two-state FSM: ISSUE (in_ready=1) and STALL (in_ready=0).
//    - Transition is evaluated every cycle from the hazard condition.
//    - STALL returns to ISSUE once the producer leaves P1/P2.
//  - flush: at posedge it forces out_valid<=0 and out_dst_we<=0, cancelling P1.
//    flush has priority over an accept in the same cycle: the instruction is dropped,
//    and in_ready is still reported so upstream advances.
//  - Simultaneous wb write and read of the same address: handled per CONFIGURATION.
//  - Reset mid-stall clears the FSM to ISSUE and drops pending state.
// CONFIGURATION
//  ALU_OPERAND_BYPASS_EN defined:
//  - Write-first read: a read of wb_addr while wb_en selects wb_data.
//  - P2 is not a hazard, so a back-to-back dependency stalls exactly 1 cycle.
//  ALU_OPERAND_BYPASS_EN undefined:
//  - The register file returns the old value during a write.
//  - P2 counts as a hazard, so a back-to-back dependency stalls 2 cycles.
// TESTING
//  - Reset: rst_n=0 for 2 cycles -> reg0=reg1=alu_op=0, out_valid=0, in_ready=1.
//  - wb write R3=0x1234, then issue src0=3, src1=0, imm unused
//    -> next cycle reg0=0x1234, reg1=0, out_valid=1.
//  - in_use_imm=1, in_imm=0xBEEF, src1=5 pending in P1 -> no stall, reg1=0xBEEF.
//  - Issue dst=4 (we), next cycle issue src0=4, writeback R4=0x00FF two cycles after the first accept:
//    - BYPASS_EN: in_ready=0 for 1 cycle, reg0=0x00FF.
//    - Without BYPASS_EN: in_ready=0 for 2 cycles, then reg0=0x00FF.
//  - Dependent on dst=0, or on dst with in_dst_we=0 -> no stall. Write to R0 -> R0 still reads 0.
//  - flush asserted with in_valid=1 -> out_valid=0 next cycle, the hazard on that dst is cleared,
//    and a following dependent instruction issues without stall.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//  Operand-fetch stage in front of the ALU: register file, two source reads,
//  optional immediate on operand 1, RAW hazard detection against the
//  instruction in the output register (P1) and the writeback bus (P2).
//  Optional feature macro: ALU_OPERAND_BYPASS_EN
//    defined   -> write-first register read, writeback bus is not a hazard
//    undefined -> read returns the old value during a write, the writeback
//                 bus counts as a hazard
// ---------------------------------------------------------------------------
module alu_operand_stage #(
   parameter int DATA_W  = 16,
   parameter int REG_CNT = 16,
   localparam int ADDR_W = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_src0,
   input  logic [ADDR_W-1:0] in_src1,
   input  logic [ADDR_W-1:0] in_dst,
   input  logic              in_dst_we,
   input  logic              in_use_imm,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [3:0]        in_op,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] reg0,
   output logic [DATA_W-1:0] reg1,
   output logic [3:0]        alu_op,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_dst,
   output logic              out_dst_we
);

`ifdef ALU_OPERAND_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
   localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

   typedef enum logic [0:0] {ST_ISSUE = 1'b0, ST_STALL = 1'b1} state_t;

   state_t            state_r, state_next_s;
   logic [DATA_W-1:0] rf_r [REG_CNT];
   logic [DATA_W-1:0] rd0_s, rd1_s, opnd1_s;
   logic              use0_s, use1_s, p1_v_s, p2_v_s;
   logic              hazard_s, in_ready_s, accept_s;
   logic [DATA_W-1:0] reg0_r, reg1_r;
   logic [3:0]        alu_op_r;
   logic              out_valid_r, out_dst_we_r;
   logic [ADDR_W-1:0] out_dst_r;

   // Register file: cleared by reset, register 0 is never written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++) rf_r[i] <= ZERO_D;
      end else if (wb_en && (wb_addr != ZERO_A)) begin
         rf_r[wb_addr] <= wb_data;
      end
   end

   // Source reads: R0 reads zero, optional write-first forwarding of the writeback bus.
   always_comb begin
      rd0_s   = ZERO_D;
      rd1_s   = ZERO_D;
      opnd1_s = ZERO_D;
      if (in_src0 == ZERO_A) rd0_s = ZERO_D;
      else if (BYPASS && wb_en && (wb_addr == in_src0)) rd0_s = wb_data;
      else rd0_s = rf_r[in_src0];
      if (in_src1 == ZERO_A) rd1_s = ZERO_D;
      else if (BYPASS && wb_en && (wb_addr == in_src1)) rd1_s = wb_data;
      else rd1_s = rf_r[in_src1];
      if (in_use_imm) opnd1_s = in_imm;
      else opnd1_s = rd1_s;
   end

   // Hazard: a used (nonzero) source matching a pending destination.
   always_comb begin
      use0_s   = (in_src0 != ZERO_A);
      use1_s   = (in_src1 != ZERO_A) && !in_use_imm;
      p1_v_s   = out_valid_r && out_dst_we_r;
      p2_v_s   = wb_en && !BYPASS;
      hazard_s = (use0_s && ((p1_v_s && (in_src0 == out_dst_r)) ||
                             (p2_v_s && (in_src0 == wb_addr)))) ||
                 (use1_s && ((p1_v_s && (in_src1 == out_dst_r)) ||
                             (p2_v_s && (in_src1 == wb_addr))));
   end

   // Issue/stall state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_r <= ST_ISSUE;
      else state_r <= state_next_s;
   end

   // Next state and ready: the hazard is re-evaluated every cycle in either state.
   always_comb begin
      state_next_s = ST_ISSUE;
      in_ready_s   = 1'b1;
      case (state_r)
         ST_ISSUE: begin
            if (hazard_s) begin
               state_next_s = ST_STALL;
               in_ready_s   = 1'b0;
            end else begin
               state_next_s = ST_ISSUE;
               in_ready_s   = 1'b1;
            end
         end
         ST_STALL: begin
            if (hazard_s) begin
               state_next_s = ST_STALL;
               in_ready_s   = 1'b0;
            end else begin
               state_next_s = ST_ISSUE;
               in_ready_s   = 1'b1;
            end
         end
         default: begin
            state_next_s = ST_ISSUE;
            in_ready_s   = !hazard_s;
         end
      endcase
      accept_s = in_valid && in_ready_s;
   end

   // Output register: flush beats accept, otherwise accept or issue a bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg0_r       <= ZERO_D;
         reg1_r       <= ZERO_D;
         alu_op_r     <= 4'h0;
         out_valid_r  <= 1'b0;
         out_dst_r    <= ZERO_A;
         out_dst_we_r <= 1'b0;
      end else if (flush) begin
         out_valid_r  <= 1'b0;
         out_dst_we_r <= 1'b0;
      end else if (accept_s) begin
         reg0_r       <= rd0_s;
         reg1_r       <= opnd1_s;
         alu_op_r     <= in_op;
         out_valid_r  <= 1'b1;
         out_dst_r    <= in_dst;
         out_dst_we_r <= in_dst_we;
      end else begin
         out_valid_r  <= 1'b0;
         out_dst_we_r <= 1'b0;
      end
   end

   assign in_ready   = in_ready_s;
   assign reg0       = reg0_r;
   assign reg1       = reg1_r;
   assign alu_op     = alu_op_r;
   assign out_valid  = out_valid_r;
   assign out_dst    = out_dst_r;
   assign out_dst_we = out_dst_we_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
//  Directed bench for alu_operand_stage (DATA_W=16, REG_CNT=16).
//  Expectations follow ALU_OPERAND_BYPASS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_src0, in_src1, in_dst;
   logic        in_dst_we, in_use_imm;
   logic [15:0] in_imm;
   logic [3:0]  in_op;
   logic        flush;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic [15:0] reg0, reg1;
   logic [3:0]  alu_op;
   logic        out_valid;
   logic [3:0]  out_dst;
   logic        out_dst_we;

   int n_checks = 0;
   int n_fail   = 0;

   alu_operand_stage #(.DATA_W(16), .REG_CNT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_src0(in_src0), .in_src1(in_src1), .in_dst(in_dst),
      .in_dst_we(in_dst_we), .in_use_imm(in_use_imm), .in_imm(in_imm),
      .in_op(in_op), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .reg0(reg0), .reg1(reg1), .alu_op(alu_op),
      .out_valid(out_valid), .out_dst(out_dst), .out_dst_we(out_dst_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] d,
                        input logic we, input logic ui, input logic [15:0] imm,
                        input logic [3:0] op);
      in_valid   = 1'b1;
      in_src0    = s0;
      in_src1    = s1;
      in_dst     = d;
      in_dst_we  = we;
      in_use_imm = ui;
      in_imm     = imm;
      in_op      = op;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      in_src0    = 4'd0;
      in_src1    = 4'd0;
      in_dst     = 4'd0;
      in_dst_we  = 1'b0;
      in_use_imm = 1'b0;
      in_imm     = 16'h0000;
      in_op      = 4'h0;
   endtask

   task automatic wb(input logic en, input logic [3:0] a, input logic [15:0] d);
      wb_en   = en;
      wb_addr = a;
      wb_data = d;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      idle();
      wb(1'b0, 4'd0, 16'h0000);

      // Reset
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_reg0", {16'h0, reg0}, 32'h0);
      chk("rst_reg1", {16'h0, reg1}, 32'h0);
      chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

      // Write R3 then read it
      wb(1'b1, 4'd3, 16'h1234);
      tick();
      wb(1'b0, 4'd0, 16'h0000);
      issue(4'd3, 4'd0, 4'd7, 1'b0, 1'b0, 16'h0000, 4'h5);
      @(negedge clk);
      chk("rd_in_ready", {31'h0, in_ready}, 32'h1);
      tick();
      chk("rd_reg0", {16'h0, reg0}, 32'h1234);
      chk("rd_reg1", {16'h0, reg1}, 32'h0);
      chk("rd_out_valid", {31'h0, out_valid}, 32'h1);
      chk("rd_alu_op", {28'h0, alu_op}, 32'h5);
      idle();
      tick();
      chk("bubble_valid", {31'h0, out_valid}, 32'h0);
      chk("bubble_hold_reg0", {16'h0, reg0}, 32'h1234);

      // Immediate bypasses a pending src1
      issue(4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 16'h0000, 4'h1);
      tick();
      chk("p1_dst", {28'h0, out_dst}, 32'h5);
      chk("p1_dst_we", {31'h0, out_dst_we}, 32'h1);
      issue(4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 16'hBEEF, 4'h2);
      @(negedge clk);
      chk("src1_haz_ready", {31'h0, in_ready}, 32'h0);
      in_use_imm = 1'b1;
      #1;
      chk("imm_ready", {31'h0, in_ready}, 32'h1);
      tick();
      chk("imm_reg1", {16'h0, reg1}, 32'hBEEF);
      chk("imm_valid", {31'h0, out_valid}, 32'h1);
      idle();
      tick();

      // Back-to-back dependency on R4
      issue(4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 16'h0000, 4'h2);
      tick();
      issue(4'd4, 4'd0, 4'd8, 1'b0, 1'b0, 16'h0000, 4'h3);
      @(negedge clk);
      chk("dep_stall1", {31'h0, in_ready}, 32'h0);
      tick();
      chk("dep_bubble", {31'h0, out_valid}, 32'h0);
      wb(1'b1, 4'd4, 16'h00FF);
      @(negedge clk);
      chk("dep_c2_ready", {31'h0, in_ready}, BYP ? 32'h1 : 32'h0);
      tick();
      wb(1'b0, 4'd0, 16'h0000);
      if (!BYP) begin
         chk("dep_c2_bubble", {31'h0, out_valid}, 32'h0);
         @(negedge clk);
         chk("dep_c3_ready", {31'h0, in_ready}, 32'h1);
         tick();
      end
      chk("dep_reg0", {16'h0, reg0}, 32'h00FF);
      chk("dep_valid", {31'h0, out_valid}, 32'h1);
      chk("dep_alu_op", {28'h0, alu_op}, 32'h3);
      idle();
      tick();

      // No hazard on dst=0 or on a non-writing dst; R0 write ignored
      issue(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0000, 4'h1);
      tick();
      issue(4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 16'h0000, 4'h1);
      @(negedge clk);
      chk("dst0_ready", {31'h0, in_ready}, 32'h1);
      tick();
      issue(4'd9, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 4'h1);
      @(negedge clk);
      chk("nowe_ready", {31'h0, in_ready}, 32'h1);
      tick();
      idle();
      wb(1'b1, 4'd0, 16'hDEAD);
      tick();
      wb(1'b0, 4'd0, 16'h0000);
      issue(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 4'h1);
      tick();
      issue(4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 16'h0000, 4'h6);
      tick();
      chk("r0_reg0", {16'h0, reg0}, 32'h0);
      chk("r0_reg1", {16'h0, reg1}, 32'h1234);

      // Flush drops the live instruction and the flushed one
      issue(4'd0, 4'd0, 4'd6, 1'b1, 1'b0, 16'h0000, 4'h7);
      tick();
      issue(4'd0, 4'd0, 4'd11, 1'b1, 1'b0, 16'h0000, 4'h8);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_ready", {31'h0, in_ready}, 32'h1);
      tick();
      flush = 1'b0;
      chk("flush_valid", {31'h0, out_valid}, 32'h0);
      chk("flush_dst_we", {31'h0, out_dst_we}, 32'h0);
      chk("flush_alu_op", {28'h0, alu_op}, 32'h7);
      issue(4'd6, 4'd11, 4'd0, 1'b0, 1'b0, 16'h0000, 4'h9);
      @(negedge clk);
      chk("post_flush_ready", {31'h0, in_ready}, 32'h1);
      tick();
      chk("post_flush_valid", {31'h0, out_valid}, 32'h1);
      idle();
      tick();

      // Reset during a stall
      issue(4'd0, 4'd0, 4'd10, 1'b1, 1'b0, 16'h0000, 4'h2);
      tick();
      issue(4'd10, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 4'h3);
      @(negedge clk);
      chk("pre_rst_stall", {31'h0, in_ready}, 32'h0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
      chk("mid_rst_alu_op", {28'h0, alu_op}, 32'h0);
      @(negedge clk);
      chk("mid_rst_ready", {31'h0, in_ready}, 32'h1);
      issue(4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 16'h0000, 4'h4);
      tick();
      chk("rf_cleared_r3", {16'h0, reg0}, 32'h0);
      chk("rf_cleared_r4", {16'h0, reg1}, 32'h0);
      chk("after_rst_valid", {31'h0, out_valid}, 32'h1);
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
